// File: rtl/if_align_buffer_if.sv
// Fetch-side and issue-side handshake bundle for if_align_buffer.
// master = icache/IFU side driving requests, slave = the alignment buffer.
interface if_align_buffer_if #(
   parameter int XLEN     = 32,
   parameter int DEPTH_HW = 8
);
   logic                        flush_i;
   logic [XLEN-1:0]             flush_pc_i;
   logic                        fetch_valid_i;
   logic                        fetch_ready_o;
   logic [XLEN-1:0]             fetch_addr_i;
   logic [31:0]                 fetch_data_i;
   logic                        inst_valid_o;
   logic                        inst_ready_i;
   logic [31:0]                 inst_o;
   logic [XLEN-1:0]             inst_addr_o;
   logic                        is_compressed_o;
   logic                        ram_stall_if_o;
   logic [$clog2(DEPTH_HW):0]   count_o;

   modport master (
      output flush_i, flush_pc_i, fetch_valid_i, fetch_addr_i, fetch_data_i, inst_ready_i,
      input  fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, is_compressed_o,
             ram_stall_if_o, count_o
   );

   modport slave (
      input  flush_i, flush_pc_i, fetch_valid_i, fetch_addr_i, fetch_data_i, inst_ready_i,
      output fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, is_compressed_o,
             ram_stall_if_o, count_o
   );
endinterface

// File: rtl/if_align_buffer.sv
// Halfword fetch alignment queue: 32-bit fetch words in, one aligned instruction out per cycle.
// Optional macro IF_ALIGN_RVC_EN enables compressed decode and RVC-to-32-bit expansion.
module if_align_buffer #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH_HW = 8,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input logic            clk,
   input logic            rst,
   if_align_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH_HW);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] READY_MARK = CW'(DEPTH_HW - 2);

   logic [15:0]     q [DEPTH_HW];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] tail_pc;
   logic            skip_lo;

   logic [15:0]     hw0;
   logic [15:0]     hw1;
   logic            is16;
   logic [31:0]     inst_sel;
   logic            head_valid;
   logic            inst_valid;
   logic            fetch_ready;
   logic            word_match;
   logic            push;
   logic            pop;
   logic [CW-1:0]   push_cnt;
   logic [CW-1:0]   pop_cnt;
   logic [XLEN-1:0] flush_base;
   logic            flush_skip;
   logic            unused_bits;

   assign hw0 = q[head];
   assign hw1 = q[head + PW'(1)];

`ifdef IF_ALIGN_RVC_EN
   localparam logic [XLEN-1:0] RESET_BASE = RESET_PC;
   localparam logic            RESET_SKIP = RESET_PC[1];

   // RV32C to RV32I expansion; reserved/illegal encodings map to all-zero (illegal).
   function automatic logic [31:0] expand_rvc(input logic [15:0] c);
      logic [4:0]  rd;
      logic [4:0]  rs2;
      logic [4:0]  rdp;
      logic [4:0]  rs1p;
      logic [11:0] imm12;
      logic [20:0] joff;
      logic [12:0] boff;
      logic [9:0]  uimm;
      logic [6:0]  off7;
      logic [7:0]  off8;
      logic [31:0] r;
      rd    = c[11:7];
      rs2   = c[6:2];
      rdp   = {2'b01, c[4:2]};
      rs1p  = {2'b01, c[9:7]};
      imm12 = {{6{c[12]}}, c[12], c[6:2]};
      joff  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
      boff  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
      uimm  = {c[10:7], c[12:11], c[5], c[6], 2'b00};
      off7  = {c[5], c[12:10], c[6], 2'b00};
      off8  = {c[3:2], c[12], c[6:4], 2'b00};
      r     = 32'h0;
      case ({c[15:13], c[1:0]})
         5'b000_00: if (uimm != 10'd0) r = {2'b00, uimm, 5'd2, 3'b000, rdp, 7'h13};
         5'b010_00: r = {5'b0, off7, rs1p, 3'b010, rdp, 7'h03};
         5'b110_00: r = {5'b0, off7[6:5], rdp, rs1p, 3'b010, off7[4:0], 7'h23};
         5'b000_01: r = {imm12, rd, 3'b000, rd, 7'h13};
         5'b001_01: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'h6f};
         5'b010_01: r = {imm12, 5'd0, 3'b000, rd, 7'h13};
         5'b011_01: begin
            if (rd == 5'd2) r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
            else            r = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
         end
         5'b100_01: begin
            case (c[11:10])
               2'b00:   r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               2'b01:   r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               2'b10:   r = {imm12, rs1p, 3'b111, rs1p, 7'h13};
               default: begin
                  case (c[6:5])
                     2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                     2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                     2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                     default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                  endcase
               end
            endcase
         end
         5'b101_01: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'h6f};
         5'b110_01: r = {boff[12], boff[10:5], 5'd0, rs1p, 3'b000, boff[4:1], boff[11], 7'h63};
         5'b111_01: r = {boff[12], boff[10:5], 5'd0, rs1p, 3'b001, boff[4:1], boff[11], 7'h63};
         5'b000_10: r = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
         5'b010_10: r = {4'b0, off8, 5'd2, 3'b010, rd, 7'h03};
         5'b100_10: begin
            if (!c[12]) begin
               if (rs2 == 5'd0) r = {12'b0, rd, 3'b000, 5'd0, 7'h67};
               else             r = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
            end else begin
               if (rd == 5'd0 && rs2 == 5'd0) r = 32'h0010_0073;
               else if (rs2 == 5'd0)         r = {12'b0, rd, 3'b000, 5'd1, 7'h67};
               else                          r = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
            end
         end
         5'b110_10: r = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
         default:   r = 32'h0;
      endcase
      return r;
   endfunction

   assign is16        = (hw0[1:0] != 2'b11);
   assign inst_sel    = is16 ? expand_rvc(hw0) : {hw1, hw0};
   assign flush_base  = bus.flush_pc_i;
   assign flush_skip  = bus.flush_pc_i[1];
   assign unused_bits = ^bus.fetch_addr_i[1:0];
`else
   // Without compressed support bit 1 of every PC is forced low, so skip_lo stays clear.
   localparam logic [XLEN-1:0] RESET_BASE = RESET_PC & ~XLEN'(2);
   localparam logic            RESET_SKIP = 1'b0;

   assign is16        = 1'b0;
   assign inst_sel    = {hw1, hw0};
   assign flush_base  = bus.flush_pc_i & ~XLEN'(2);
   assign flush_skip  = 1'b0;
   assign unused_bits = ^{bus.fetch_addr_i[1:0], bus.flush_pc_i[1]};
`endif

   // Ready derives only from the registered count so the icache sees no combinational path back.
   assign fetch_ready = (count <= READY_MARK);
   assign word_match  = (bus.fetch_addr_i[XLEN-1:2] == tail_pc[XLEN-1:2]);
   assign push        = bus.fetch_valid_i && fetch_ready && word_match && !bus.flush_i;
   assign push_cnt    = !push ? '0 : (skip_lo ? CW'(1) : CW'(2));

   assign head_valid  = is16 ? (count != '0) : (count >= CW'(2));
   assign inst_valid  = head_valid && !bus.flush_i;
   assign pop         = inst_valid && bus.inst_ready_i;
   assign pop_cnt     = !pop ? '0 : (is16 ? CW'(1) : CW'(2));

   assign bus.fetch_ready_o   = fetch_ready;
   assign bus.inst_valid_o    = inst_valid;
   assign bus.inst_o          = inst_valid ? inst_sel : 32'h0;
   assign bus.inst_addr_o     = inst_valid ? head_pc : '0;
   assign bus.is_compressed_o = inst_valid && is16;
   assign bus.ram_stall_if_o  = !inst_valid && !bus.flush_i;
   assign bus.count_o         = count;

   // Queue storage is not reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         if (skip_lo) begin
            q[tail] <= bus.fetch_data_i[31:16];
         end else begin
            q[tail]           <= bus.fetch_data_i[15:0];
            q[tail + PW'(1)]  <= bus.fetch_data_i[31:16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         head    <= '0;
         tail    <= '0;
         head_pc <= RESET_BASE;
         tail_pc <= RESET_BASE;
         skip_lo <= RESET_SKIP;
      end else if (bus.flush_i) begin
         count   <= '0;
         head    <= '0;
         tail    <= '0;
         head_pc <= flush_base;
         tail_pc <= flush_base;
         skip_lo <= flush_skip;
      end else begin
         if (push) begin
            tail    <= tail + push_cnt[PW-1:0];
            tail_pc <= tail_pc + XLEN'(4);
            skip_lo <= 1'b0;
         end
         if (pop) begin
            head    <= head + pop_cnt[PW-1:0];
            head_pc <= head_pc + (is16 ? XLEN'(2) : XLEN'(4));
         end
         count <= count + push_cnt - pop_cnt;
      end
   end
endmodule

// File: tb/tb_if_align_buffer.sv
// Self-checking bench for if_align_buffer: directed scenarios plus randomized traffic
// checked against a halfword-queue reference model.
module tb_if_align_buffer;
   localparam int XLEN  = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IF_ALIGN_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   if_align_buffer_if #(.XLEN(XLEN), .DEPTH_HW(DEPTH)) bus ();

   if_align_buffer #(.XLEN(XLEN), .DEPTH_HW(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: live halfwords, PC of the oldest one, next expected word address.
   logic [15:0] mq [$];
   logic [31:0] m_pc;
   logic [29:0] m_word;
   bit          m_skip;
   bit          e_valid;
   bit          e_isc;
   bit          e_ready;
   bit          e_stall;
   logic [31:0] e_inst;
   logic [31:0] e_addr;
   int          e_count;

   task automatic applyStimulus(input bit fl, input logic [31:0] fpc, input bit fv,
                                input logic [31:0] fa, input logic [31:0] fd, input bit rdy);
      bus.flush_i       = fl;
      bus.flush_pc_i    = fpc;
      bus.fetch_valid_i = fv;
      bus.fetch_addr_i  = fa;
      bus.fetch_data_i  = fd;
      bus.inst_ready_i  = rdy;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Only c.li / c.addi are generated, so expansion is plain immediate arithmetic.
   function automatic logic [31:0] ref_expand(input logic [15:0] c);
      int imm;
      int rd;
      int rs1;
      imm = int'(c[6:2]) - (c[12] ? 32 : 0);
      rd  = int'(c[11:7]);
      rs1 = (c[15:13] == 3'b010) ? 0 : rd;
      return ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
   endfunction

   function automatic logic [15:0] gen_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if (h[1:0] != 2'b11) begin
         h[1:0]   = 2'b01;
         h[15:13] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010;
      end
      return h;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc   = RESET_PC;
      m_word = m_pc[31:2];
      m_skip = 1'b0;
   endtask

   task automatic model_expect(input bit fl);
      logic [15:0] h0;
      e_count = mq.size();
      e_ready = (mq.size() <= DEPTH - 2);
      e_valid = 1'b0;
      e_isc   = 1'b0;
      e_inst  = 32'h0;
      e_addr  = 32'h0;
      h0      = (mq.size() > 0) ? mq[0] : 16'h0;
      if (RVC && mq.size() >= 1 && h0[1:0] != 2'b11) begin
         e_valid = 1'b1;
         e_isc   = 1'b1;
         e_inst  = ref_expand(h0);
      end else if (mq.size() >= 2 && (!RVC || h0[1:0] == 2'b11)) begin
         e_valid = 1'b1;
         e_inst  = {mq[1], h0};
      end
      if (fl) e_valid = 1'b0;
      if (!e_valid) begin
         e_isc  = 1'b0;
         e_inst = 32'h0;
      end else begin
         e_addr = m_pc;
      end
      e_stall = !e_valid && !fl;
   endtask

   task automatic model_commit(input bit r, input bit fl, input logic [31:0] fpc, input bit fv,
                               input logic [31:0] fa, input logic [31:0] fd, input bit rdy);
      logic [31:0] tgt;
      if (r) begin
         model_reset();
      end else if (fl) begin
         tgt    = RVC ? fpc : (fpc & ~32'h2);
         mq.delete();
         m_pc   = tgt;
         m_word = tgt[31:2];
         m_skip = RVC && tgt[1];
      end else begin
         if (e_valid && rdy) begin
            void'(mq.pop_front());
            if (e_isc) begin
               m_pc = m_pc + 2;
            end else begin
               void'(mq.pop_front());
               m_pc = m_pc + 4;
            end
         end
         if (fv && e_ready && fa[31:2] == m_word) begin
            if (!m_skip) mq.push_back(fd[15:0]);
            mq.push_back(fd[31:16]);
            m_word = m_word + 1;
            m_skip = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (bus.count_o !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count_o); end
      checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.inst_valid_o); end
      checks++; if (bus.inst_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got=%h exp=0", bus.inst_o); end
      checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.fetch_ready_o); end
      checks++; if (bus.ram_stall_if_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=1", bus.ram_stall_if_o); end
   endtask

   task automatic test_single();
      applyStimulus(0, 0, 1, 32'h8000_0000, 32'h0000_0013, 0);
      checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_latency got=%b exp=0", bus.inst_valid_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%b exp=1", bus.inst_valid_o); end
      checks++; if (bus.inst_o !== 32'h0000_0013) begin errors++; $display("[TB] FAIL single_inst got=%h exp=00000013", bus.inst_o); end
      checks++; if (bus.inst_addr_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL single_addr got=%h exp=80000000", bus.inst_addr_o); end
      checks++; if (bus.is_compressed_o !== 1'b0) begin errors++; $display("[TB] FAIL single_isc got=%b exp=0", bus.is_compressed_o); end
      checks++; if (bus.count_o !== CW'(2)) begin errors++; $display("[TB] FAIL single_count got=%0d exp=2", bus.count_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (bus.inst_valid_o !== 1'b0 || bus.count_o !== CW'(0)) begin errors++; $display("[TB] FAIL single_drain valid=%b count=%0d exp 0/0", bus.inst_valid_o, bus.count_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 32'h8000_0004 + 32'(4 * i), 32'h13 | 32'(i << 7), 0);
         step();
      end
      applyStimulus(0, 0, 1, 32'h8000_0014, 32'h0000_0013, 0);
      checks++; if (bus.count_o !== CW'(8)) begin errors++; $display("[TB] FAIL fill_count got=%0d exp=8", bus.count_o); end
      checks++; if (bus.fetch_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready got=%b exp=0", bus.fetch_ready_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.count_o !== CW'(8)) begin errors++; $display("[TB] FAIL full_hold_count got=%0d exp=8", bus.count_o); end
      checks++; if (bus.inst_addr_o !== 32'h8000_0004 || bus.inst_o !== 32'h0000_0013) begin errors++; $display("[TB] FAIL full_head got=%h@%h exp=00000013@80000004", bus.inst_o, bus.inst_addr_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (bus.fetch_ready_o !== 1'b1 || bus.count_o !== CW'(6)) begin errors++; $display("[TB] FAIL pop_reopen ready=%b count=%0d exp 1/6", bus.fetch_ready_o, bus.count_o); end
      checks++; if (bus.inst_addr_o !== 32'h8000_0008 || bus.inst_o !== 32'h0000_0093) begin errors++; $display("[TB] FAIL pop_next got=%h@%h exp=00000093@80000008", bus.inst_o, bus.inst_addr_o); end
   endtask

   task automatic test_flush_stale();
      applyStimulus(1, 32'h8000_0200, 1, 32'h8000_0014, 32'h0000_0013, 1);
      checks++; if (bus.inst_valid_o !== 1'b0 || bus.ram_stall_if_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle valid=%b stall=%b exp 0/0", bus.inst_valid_o, bus.ram_stall_if_o); end
      step();
      applyStimulus(0, 0, 1, 32'h8000_0010, 32'h0000_0013, 0);
      checks++; if (bus.fetch_ready_o !== 1'b1 || bus.count_o !== CW'(0)) begin errors++; $display("[TB] FAIL flush_empty ready=%b count=%0d exp 1/0", bus.fetch_ready_o, bus.count_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (bus.count_o !== CW'(0) || bus.ram_stall_if_o !== 1'b1) begin errors++; $display("[TB] FAIL stale_drop count=%0d stall=%b exp 0/1", bus.count_o, bus.ram_stall_if_o); end
      applyStimulus(0, 0, 1, 32'h8000_0200, 32'h00A0_0093, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_addr_o !== 32'h8000_0200 || bus.inst_o !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL flush_target got=%h@%h exp=00a00093@80000200", bus.inst_o, bus.inst_addr_o); end
      step();
   endtask

`ifdef IF_ALIGN_RVC_EN
   task automatic test_rvc();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b0;
      applyStimulus(0, 0, 1, 32'h8000_0000, 32'h4505_4501, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_o !== 32'h0000_0513 || bus.inst_addr_o !== 32'h8000_0000 || bus.is_compressed_o !== 1'b1) begin errors++; $display("[TB] FAIL rvc_pair0 got=%h@%h c=%b", bus.inst_o, bus.inst_addr_o, bus.is_compressed_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_o !== 32'h0010_0513 || bus.inst_addr_o !== 32'h8000_0002 || bus.is_compressed_o !== 1'b1) begin errors++; $display("[TB] FAIL rvc_pair1 got=%h@%h c=%b", bus.inst_o, bus.inst_addr_o, bus.is_compressed_o); end
      step();
      applyStimulus(0, 0, 1, 32'h8000_0004, 32'h0513_4505, 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_o !== 32'h0010_0513 || bus.inst_addr_o !== 32'h8000_0004) begin errors++; $display("[TB] FAIL rvc_cli got=%h@%h", bus.inst_o, bus.inst_addr_o); end
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_valid_o !== 1'b0 || bus.count_o !== CW'(1)) begin errors++; $display("[TB] FAIL straddle_wait valid=%b count=%0d exp 0/1", bus.inst_valid_o, bus.count_o); end
      applyStimulus(0, 0, 1, 32'h8000_0008, 32'h0000_0010, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 1);
      checks++; if (bus.inst_o !== 32'h0010_0513 || bus.inst_addr_o !== 32'h8000_0006 || bus.is_compressed_o !== 1'b0) begin errors++; $display("[TB] FAIL straddle got=%h@%h c=%b", bus.inst_o, bus.inst_addr_o, bus.is_compressed_o); end
      step();
      applyStimulus(1, 32'h8000_0102, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 1, 32'h8000_0100, 32'h4505_ABCD, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++; if (bus.count_o !== CW'(1)) begin errors++; $display("[TB] FAIL odd_target_count got=%0d exp=1", bus.count_o); end
      checks++; if (bus.inst_o !== 32'h0010_0513 || bus.inst_addr_o !== 32'h8000_0102 || bus.is_compressed_o !== 1'b1) begin errors++; $display("[TB] FAIL odd_target got=%h@%h c=%b", bus.inst_o, bus.inst_addr_o, bus.is_compressed_o); end
   endtask
`endif

   task automatic test_random();
      bit          r;
      bit          fl;
      bit          fv;
      bit          rdy;
      logic [31:0] fpc;
      logic [31:0] fa;
      logic [31:0] fd;
      logic [1:0]  lowb;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         r    = ($urandom_range(0, 99) == 0);
         fl   = ($urandom_range(0, 19) == 0);
         fpc  = 32'h8000_0000 + 32'($urandom_range(0, 511) << 1);
         fv   = ($urandom_range(0, 3) != 0);
         lowb = 2'($urandom_range(0, 3));
         fa   = ($urandom_range(0, 3) != 0) ? {m_word, lowb} : {m_word + 30'($urandom_range(1, 3)), 2'b00};
         fd   = {gen_hw(), gen_hw()};
         rdy  = ($urandom_range(0, 9) < 6);
         rst  = r;
         applyStimulus(fl, fpc, fv, fa, fd, rdy);
         model_expect(fl);
         checks++;
         if ({bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, bus.is_compressed_o, bus.fetch_ready_o, bus.ram_stall_if_o, bus.count_o}
             !== {e_valid, e_inst, e_addr, e_isc, e_ready, e_stall, CW'(e_count)}) begin
            errors++;
            $display("[TB] FAIL random_c%0d got v=%b i=%h a=%h c=%b rdy=%b st=%b n=%0d exp v=%b i=%h a=%h c=%b rdy=%b st=%b n=%0d",
                     cyc, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, bus.is_compressed_o, bus.fetch_ready_o,
                     bus.ram_stall_if_o, bus.count_o, e_valid, e_inst, e_addr, e_isc, e_ready, e_stall, e_count);
         end
         model_commit(r, fl, fpc, fv, fa, fd, rdy);
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      test_reset();
      test_single();
      test_fill();
      test_flush_stale();
`ifdef IF_ALIGN_RVC_EN
      test_rvc();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
